// File: rtl/seir_pkg.sv
// seir_pkg: shared compartment encoding and LFSR constants for the SEIR agent
//
// Contents:
//   seir_state_t  - 2-bit compartment type (SUS=0, EXP=1, INF=2, REC=3)
//   LFSR_TAPS16   - Galois feedback mask for the 16-bit agent LFSR
//   SEED_XOR      - constant XORed into the seed of the second LFSR
//   lfsr_taps()   - picks a feedback mask for a given LFSR width
package seir_pkg;

    typedef enum logic [1:0] {
        SUS = 2'd0,
        EXP = 2'd1,
        INF = 2'd2,
        REC = 2'd3
    } seir_state_t;

    localparam logic [15:0] LFSR_TAPS16 = 16'hB400;
    localparam logic [15:0] SEED_XOR    = 16'hACE1;

    // Maximal-length right-shift Galois masks; other widths reuse the 16-bit mask.
    function automatic logic [31:0] lfsr_taps(input int w);
        return (w == 8) ? 32'h0000_00B8 : {16'h0000, LFSR_TAPS16};
    endfunction

endpackage

// File: rtl/agent_lfsr.sv
// agent_lfsr: free-running right-shift Galois LFSR with synchronous seed load
//
// Parameters:
//   W     - register width
//   TAPS  - feedback mask XORed in when the shifted-out bit is 1
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (value returns to 1)
//   load   in   replace the register with seed on the next edge
//   seed   in   W-bit seed; an all-zero seed is replaced by 1
//   value  out  current LFSR state
module agent_lfsr
    import seir_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS16)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q, value_d;

    // Zero is the lock-up state of an XOR LFSR, so it is never loaded.
    always_comb value_d = load ? ((seed == '0) ? W'(1) : seed)
                               : ((value_q >> 1) ^ (value_q[0] ? TAPS : '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= W'(1);
        else        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/seir_agent.sv
// seir_agent: one SEIR(S) node of the network disease simulator
//
// Build option: define SEIR_WANING_IMMUNITY_EN to let REC return to SUS after
// imm_period cycles; otherwise REC is absorbing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   neighbour_edges     infection requests from other agents (any bit infects)
//   output_edges        infection requests to neighbours (connectivity & tx_fire)
//   address             target node of the load strobes below
//   seed_value/load_seed            reseed both LFSRs
//   init_state/load_state           force the compartment (beats transitions)
//   curr_state                      current compartment
//   val_connectivity/load_connectivity  write next 32-bit connectivity word
//   tx_thresh           transmit when tx LFSR < tx_thresh (0 disables)
//   exp_period, inf_period, imm_period  dwell lengths, sampled on state entry
module seir_agent
    import seir_pkg::*;
#(
    parameter logic [31:0] NODE_ADDR  = 32'd0,
    parameter int          NUM_AGENTS = 100,
    parameter int          RAND_W     = 16,
    parameter int          CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_AGENTS-1:0] neighbour_edges,
    output logic [NUM_AGENTS-1:0] output_edges,
    input  logic [31:0]           address,
    input  logic [31:0]           seed_value,
    input  logic                  load_seed,
    input  logic [1:0]            init_state,
    input  logic                  load_state,
    output logic [1:0]            curr_state,
    input  logic                  load_connectivity,
    input  logic [31:0]           val_connectivity,
    input  logic [RAND_W-1:0]     tx_thresh,
    input  logic [CNT_W-1:0]      exp_period,
    input  logic [CNT_W-1:0]      inf_period,
    input  logic [CNT_W-1:0]      imm_period
);

    localparam int NW    = (NUM_AGENTS + 31) / 32;
    localparam int OFF_W = (NW > 1) ? $clog2(NW) : 1;

    seir_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_AGENTS-1:0] conn_q, conn_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  fire_q, fire_d;

    logic                  sel, wr_conn, ld_state, last;
    seir_state_t           ld_target;
    logic [CNT_W-1:0]      ld_period, cnt_dec;
    logic [RAND_W-1:0]     rec_seed, tx_seed, tx_rand;
    logic [RAND_W-1:0]     rec_rand_unused;
    logic [31:0]           seed_unused;

    assign sel       = (address == NODE_ADDR);
    assign wr_conn   = sel && load_connectivity;
    assign ld_state  = sel && load_state;
    assign ld_target = seir_state_t'(init_state);

    // Only the low RAND_W seed bits feed the LFSRs.
    assign seed_unused = seed_value;
    assign rec_seed    = seed_value[RAND_W-1:0];
    assign tx_seed     = rec_seed ^ RAND_W'(SEED_XOR);

    agent_lfsr #(.W(RAND_W), .TAPS(RAND_W'(lfsr_taps(RAND_W)))) u_rec_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sel && load_seed),
        .seed  (rec_seed),
        .value (rec_rand_unused)
    );

    agent_lfsr #(.W(RAND_W), .TAPS(RAND_W'(lfsr_taps(RAND_W)))) u_tx_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sel && load_seed),
        .seed  (tx_seed),
        .value (tx_rand)
    );

    // Each bit takes its value from the word slot the offset currently points at;
    // bits past NUM_AGENTS in the last word simply have no destination.
    for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_conn
        assign conn_d[i] = (wr_conn && off_q == OFF_W'(i / 32)) ? val_connectivity[i % 32] : conn_q[i];
    end

    assign off_d = !wr_conn ? off_q : (off_q == OFF_W'(NW - 1)) ? '0 : off_q + 1'b1;

    // A counter of 0 or 1 both mean the current cycle is the last of the dwell.
    assign last    = (cnt_q <= CNT_W'(1));
    assign cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

    assign ld_period = (ld_target == EXP) ? exp_period :
                       (ld_target == INF) ? inf_period :
                       (ld_target == REC) ? imm_period : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_dec;
        if (ld_state) begin
            state_d = ld_target;
            cnt_d   = ld_period;
        end else begin
            case (state_q)
                SUS: if (|neighbour_edges) begin
                    state_d = EXP;
                    cnt_d   = exp_period;
                end
                EXP: if (last) begin
                    state_d = INF;
                    cnt_d   = inf_period;
                end
                INF: if (last) begin
                    state_d = REC;
                    cnt_d   = imm_period;
                end
`ifdef SEIR_WANING_IMMUNITY_EN
                REC: if (last) begin
                    state_d = SUS;
                    cnt_d   = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    // The fire decision uses the state before this edge; a forced move out of
    // INF suppresses it so the node stops transmitting with its new state.
    assign fire_d = (ld_state && ld_target != INF) ? 1'b0 : (state_q == INF) && (tx_rand < tx_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SUS;
            cnt_q   <= '0;
            conn_q  <= '0;
            off_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            conn_q  <= conn_d;
            off_q   <= off_d;
            fire_q  <= fire_d;
        end
    end

    assign curr_state   = state_q;
    assign output_edges = conn_q & {NUM_AGENTS{fire_q}};

endmodule

// File: tb/tb_seir_agent.sv
// tb_seir_agent: scoreboard bench for seir_agent against a dwell-count reference model
`timescale 1ns/1ps
module tb_seir_agent;

    localparam int NA   = 40;
    localparam int ADDR = 5;
    localparam int RW   = 16;
    localparam int CW   = 8;
    localparam int NW   = (NA + 31) / 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NA-1:0] neighbour_edges = '0;
    logic [NA-1:0] output_edges;
    logic [31:0]   address = 32'(ADDR);
    logic [31:0]   seed_value = '0;
    logic          load_seed = 1'b0;
    logic [1:0]    init_state = '0;
    logic          load_state = 1'b0;
    logic [1:0]    curr_state;
    logic          load_connectivity = 1'b0;
    logic [31:0]   val_connectivity = '0;
    logic [RW-1:0] tx_thresh = '0;
    logic [CW-1:0] exp_period = '0, inf_period = '0, imm_period = '0;

    seir_agent #(.NODE_ADDR(32'(ADDR)), .NUM_AGENTS(NA), .RAND_W(RW), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .neighbour_edges   (neighbour_edges),
        .output_edges      (output_edges),
        .address           (address),
        .seed_value        (seed_value),
        .load_seed         (load_seed),
        .init_state        (init_state),
        .load_state        (load_state),
        .curr_state        (curr_state),
        .load_connectivity (load_connectivity),
        .val_connectivity  (val_connectivity),
        .tx_thresh         (tx_thresh),
        .exp_period        (exp_period),
        .inf_period        (inf_period),
        .imm_period        (imm_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    st;
        logic [NA-1:0] oe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: compartment plus the number of cycles still to spend in it.
    int          m_state, m_left, m_off;
    logic [31:0] m_conn [NW];
    logic        m_fire;
    logic [15:0] m_tx;

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] nz(input logic [15:0] v);
        return (v == 16'h0) ? 16'h1 : v;
    endfunction

    function automatic int dwell(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int period_for(input int s);
        return (s == 1) ? dwell(int'(exp_period)) : (s == 2) ? dwell(int'(inf_period)) : dwell(int'(imm_period));
    endfunction

    task automatic m_reset();
        m_state = 0;
        m_left  = 0;
        m_off   = 0;
        m_fire  = 1'b0;
        m_tx    = 16'h1;
        for (int w = 0; w < NW; w++) m_conn[w] = '0;
    endtask

    // Advance the model by one edge with the inputs currently driven, queue the
    // expected outputs, then let the DUT take the same edge.
    task automatic tick();
        exp_t                e;
        logic                sel, n_fire;
        logic [NW*32-1:0]    flat;
        sel    = (address == 32'(ADDR));
        n_fire = (m_state == 2) && (m_tx < tx_thresh);
        if (sel && load_state && init_state != 2'd2) n_fire = 1'b0;
        m_tx = (sel && load_seed) ? nz(seed_value[15:0] ^ 16'hACE1) : galois(m_tx);
        if (sel && load_connectivity) begin
            m_conn[m_off] = val_connectivity;
            m_off = (m_off + 1) % NW;
        end
        if (sel && load_state) begin
            m_state = int'(init_state);
            m_left  = period_for(m_state);
        end else if (m_state == 0) begin
            if (neighbour_edges != '0) begin
                m_state = 1;
                m_left  = period_for(1);
            end
        end else if (m_state == 1 || m_state == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_state = m_state + 1;
                m_left  = period_for(m_state);
            end
        end else begin
`ifdef SEIR_WANING_IMMUNITY_EN
            m_left--;
            if (m_left == 0) m_state = 0;
`endif
        end
        m_fire = n_fire;
        for (int w = 0; w < NW; w++) flat[w*32 +: 32] = m_conn[w];
        e.st = 2'(m_state);
        e.oe = m_fire ? flat[NA-1:0] : '0;
        q.push_back(e);
        @(posedge clk);
        #2;
        load_seed = 1'b0;
        load_state = 1'b0;
        load_connectivity = 1'b0;
        neighbour_edges = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (curr_state !== 2'd0 || output_edges !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d edges=%h, want state=0 edges=0", curr_state, output_edges);
        end
        m_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (curr_state !== e.st) begin
                    errors++;
                    $display("FAIL curr_state @%0t: got %0d want %0d", $time, curr_state, e.st);
                end
                checks++;
                if (output_edges !== e.oe) begin
                    errors++;
                    $display("FAIL output_edges @%0t: got %h want %h", $time, output_edges, e.oe);
                end
            end
        end
    end

    initial begin : stim
        int fires;
        #1;
        do_reset();
        // Infection timeline: exposed 3 cycles, infectious 4 cycles, then REC.
        exp_period = 8'd3; inf_period = 8'd4; imm_period = 8'd1; tx_thresh = '0;
        repeat (4) tick();
        neighbour_edges = 40'h1;
        tick();
        repeat (12) tick();
        // Connectivity word then forced INF with a saturated threshold.
        val_connectivity = 32'h0000_000F; load_connectivity = 1'b1;
        tick();
        tx_thresh = '1; init_state = 2'd2; load_state = 1'b1;
        tick();
        repeat (3) tick();
        // Loads addressed to another node must be ignored.
        address = 32'(ADDR + 1);
        init_state = 2'd0; load_state = 1'b1;
        val_connectivity = $urandom; load_connectivity = 1'b1;
        seed_value = $urandom; load_seed = 1'b1;
        tick();
        repeat (3) tick();
        address = 32'(ADDR);
        // Three writes on a 40-agent node: the third wraps back onto word 0.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            val_connectivity = $urandom; load_connectivity = 1'b1;
            tick();
        end
        tick();
        // Threshold 0 keeps an infectious node silent.
        tx_thresh = '0; inf_period = 8'd255;
        for (int i = 0; i < 1000; i++) begin
            if (i % 200 == 0) begin init_state = 2'd2; load_state = 1'b1; end
            tick();
        end
        // Seed 0, half-range threshold: fire rate near one half.
        val_connectivity = 32'hFFFF_FFFF; load_connectivity = 1'b1;
        seed_value = 32'h0; load_seed = 1'b1;
        tick();
        tx_thresh = 16'h8000;
        fires = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 200 == 0) begin init_state = 2'd2; load_state = 1'b1; end
            tick();
            if (output_edges != '0) fires++;
        end
        checks++;
        if (fires < 400 || fires > 600) begin
            errors++;
            $display("FAIL fire_rate: got %0d of 1000, want 400..600", fires);
        end
        // A seed whose XOR image is zero.
        seed_value = 32'h0000_ACE1; load_seed = 1'b1;
        tick();
        repeat (20) tick();
        // Forced SUS coinciding with the end of an EXP dwell.
        init_state = 2'd0; load_state = 1'b1;
        tick();
        exp_period = 8'd1; neighbour_edges = 40'h80_0000_0000;
        tick();
        init_state = 2'd0; load_state = 1'b1;
        tick();
        repeat (3) tick();
        // REC is absorbing in the default build.
        imm_period = 8'd1; init_state = 2'd3; load_state = 1'b1;
        tick();
        for (int i = 0; i < 500; i++) begin
            neighbour_edges = NA'({$urandom, $urandom});
            tick();
        end
        // Reset in the middle of an infectious dwell.
        tx_thresh = '1; inf_period = 8'd50; init_state = 2'd2; load_state = 1'b1;
        tick();
        repeat (3) tick();
        do_reset();
        repeat (3) tick();
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            address           = ($urandom_range(0, 3) == 0) ? $urandom : 32'(ADDR);
            neighbour_edges   = ($urandom_range(0, 9) == 0) ? NA'({$urandom, $urandom}) : '0;
            load_seed         = ($urandom_range(0, 49) == 0);
            seed_value        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            init_state        = 2'($urandom);
            load_state        = ($urandom_range(0, 19) == 0);
            load_connectivity = ($urandom_range(0, 9) == 0);
            val_connectivity  = $urandom;
            case ($urandom_range(0, 3))
                0: tx_thresh = '0;
                1: tx_thresh = '1;
                2: tx_thresh = 16'h8000;
                default: tx_thresh = RW'($urandom);
            endcase
            exp_period = CW'($urandom_range(0, 5));
            inf_period = CW'($urandom_range(0, 5));
            imm_period = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
